control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters (name, default, meaning): OPW, 5, opcode width; ALUW, 5, ALU operation code width; OP_BR, 5'h12, branch opcode; OP_JR, 5'h13, jump-register opcode; OP_JAL, 5'h14, jump-and-link opcode; OP_NOP, 5'h1A, no-op opcode; OP_HALT, 5'h1B, halt opcode; ALU_ADD, 5'h03, ALU add code.
REQ-002 Ports (name, direction, width, meaning):
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- opcode  input  OPW  IR[31:27], sampled in T3.
- con_ff  input  1  branch-condition flag from the CON_in flip-flop.
- stop  input  1  halt request, honoured at instruction boundary.
- PCout, Zlowout, MDRout, Cout  output  1 each  bus drive selects.
- MARin, MDRin, IRin, PCin, Yin, Zin  output  1 each  register load enables.
- IncPC, Read  output  1 each  PC increment, memory read.
- GRA, GRB, GRC, Rin, Rout, BAout  output  1 each  select-and-encode controls.
- CONin  output  1  load branch-condition flip-flop.
- LinkIn  output  1  load link register R8.
- operation  output  ALUW  ALU operation code.
- run  output  1  high while executing, low when halted.

Function
REQ-003 One state per clock; every output is a registered-free decode of current state only (Moore); asserted for the whole cycle.
REQ-004 States: RST, T0, T1, T2, DEC, JR3, JAL3, JAL4, BR3, BR4, BR5, BR6, HALT.
REQ-005 RST -> T0 on first edge after Reset deasserts; outputs all 0, operation 0, run 0.
REQ-006 T0: PCout, MARin, IncPC, Zin, operation=ALU_ADD -> T1.
REQ-007 T1: Zlowout, PCin, Read, MDRin -> T2.
REQ-008 T2: MDRout, IRin -> DEC.
REQ-009 DEC: no strobes; branch on opcode: OP_JR->JR3, OP_JAL->JAL3, OP_BR->BR3, OP_HALT->HALT, OP_NOP or any other->T0 (unsupported opcodes execute as NOP).
REQ-010 JR3: GRA, Rout, PCin -> T0; jr latency 5 cycles fetch-to-fetch.
REQ-011 JAL3: PCout, LinkIn -> JAL4; JAL4: GRA, Rout, PCin -> T0.
REQ-012 BR3: GRA, Rout, CONin -> BR4; BR4: PCout, Yin -> BR5; BR5: Cout, Zin, operation=ALU_ADD -> BR6; BR6: Zlowout, PCin only if con_ff=1 -> T0.
REQ-013 run=1 in all states except RST and HALT.
REQ-014 stop sampled only when leaving DEC-successor last step (entering T0); stop=1 there -> HALT instead of T0; stop mid-instruction never truncates the sequence.
REQ-015 HALT: all strobes 0; held until Reset, ignoring stop and opcode.
REQ-016 Simultaneous stop and OP_HALT in DEC -> HALT.
REQ-017 No two bus-drive selects (PCout, Zlowout, MDRout, Cout, Rout) asserted in the same state.

Reset
REQ-018 Reset asynchronously forces RST and all outputs to 0 within the same cycle, including mid-instruction; no partial strobe persists.

Configuration
REQ-019 Macro CTRL_SEQ_JAL_EN: defined -> OP_JAL executes per REQ-011; undefined -> JAL3/JAL4 absent, LinkIn tied 0, OP_JAL executes as NOP.

Structure
REQ-020 State encoding enum, opcode constants and ALU_ADD live in shared package cpu_ctrl_pkg.
REQ-021 Optional sub-module ctrl_decode: pure combinational state-to-strobe table; no other sub-modules.

Verification
REQ-022 Reset 3 cycles, release -> RST, T0 with PCout=MARin=IncPC=Zin=1, operation=5'h03, run=1.
REQ-023 opcode=5'h13 -> T0,T1,T2,DEC,JR3 with GRA=Rout=PCin=1, then T0; 5 cycles.
REQ-024 opcode=5'h12, con_ff=0 then 1 -> BR6 PCin=0 then PCin=1, Zlowout=1 both times.
REQ-025 opcode=5'h14 with CTRL_SEQ_JAL_EN -> JAL3 LinkIn=1, JAL4 PCin=1; without -> DEC->T0, LinkIn never 1.
REQ-026 stop=1 pulsed during BR4 -> branch completes, next state HALT, run=0; opcode=5'h1B -> HALT held 20 cycles.
REQ-027 Reset asserted mid-BR5 -> all outputs 0 immediately, restart at T0; bus-select exclusivity assertion checked every cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding, opcodes and strobe bundle for the control sequencer.
// CTRL_SEQ_JAL_EN adds the JAL3/JAL4 states to the encoding.
package cpu_ctrl_pkg;

  localparam int OPC_W = 5;
  localparam int ALUOP_W = 5;

  localparam logic [OPC_W-1:0] OPC_BR   = 5'h12;
  localparam logic [OPC_W-1:0] OPC_JR   = 5'h13;
  localparam logic [OPC_W-1:0] OPC_JAL  = 5'h14;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'h1A;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'h1B;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'h03;

  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_DEC,
    ST_JR3,
`ifdef CTRL_SEQ_JAL_EN
    ST_JAL3,
    ST_JAL4,
`endif
    ST_BR3,
    ST_BR4,
    ST_BR5,
    ST_BR6,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic c_out;
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic pc_in;
    logic y_in;
    logic z_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic con_in;
    logic link_in;
    logic run;
  } ctrl_strobe_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational state-to-strobe table (Moore decode; BR6 PCin also gated by con_ff).
// CTRL_SEQ_JAL_EN enables the JAL3/JAL4 rows.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int ALUW = 5,
  parameter logic [ALUW-1:0] ALU_ADD = ALUOP_ADD
) (
  input  state_t             state,
  input  logic               con_ff,
  output ctrl_strobe_t       strobes,
  output logic [ALUW-1:0]    operation
);

  always_comb begin
    strobes   = '0;
    operation = '0;
    strobes.run = (state != ST_RST) && (state != ST_HALT);
    case (state)
      ST_T0: begin
        strobes.pc_out = 1'b1;
        strobes.mar_in = 1'b1;
        strobes.inc_pc = 1'b1;
        strobes.z_in   = 1'b1;
        operation      = ALU_ADD;
      end
      ST_T1: begin
        strobes.zlow_out = 1'b1;
        strobes.pc_in    = 1'b1;
        strobes.read     = 1'b1;
        strobes.mdr_in   = 1'b1;
      end
      ST_T2: begin
        strobes.mdr_out = 1'b1;
        strobes.ir_in   = 1'b1;
      end
      ST_JR3: begin
        strobes.gra   = 1'b1;
        strobes.r_out = 1'b1;
        strobes.pc_in = 1'b1;
      end
`ifdef CTRL_SEQ_JAL_EN
      // Return address is captured before the jump target overwrites PC.
      ST_JAL3: begin
        strobes.pc_out  = 1'b1;
        strobes.link_in = 1'b1;
      end
      ST_JAL4: begin
        strobes.gra   = 1'b1;
        strobes.r_out = 1'b1;
        strobes.pc_in = 1'b1;
      end
`endif
      ST_BR3: begin
        strobes.gra    = 1'b1;
        strobes.r_out  = 1'b1;
        strobes.con_in = 1'b1;
      end
      ST_BR4: begin
        strobes.pc_out = 1'b1;
        strobes.y_in   = 1'b1;
      end
      ST_BR5: begin
        strobes.c_out = 1'b1;
        strobes.z_in  = 1'b1;
        operation     = ALU_ADD;
      end
      ST_BR6: begin
        strobes.zlow_out = 1'b1;
        strobes.pc_in    = con_ff;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute control FSM for JR, JAL, BR, NOP and HALT.
// CTRL_SEQ_JAL_EN enables jump-and-link; otherwise OP_JAL executes as a NOP.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int ALUW = 5,
  parameter logic [OPW-1:0]  OP_BR   = OPC_BR,
  parameter logic [OPW-1:0]  OP_JR   = OPC_JR,
  parameter logic [OPW-1:0]  OP_JAL  = OPC_JAL,
  parameter logic [OPW-1:0]  OP_NOP  = OPC_NOP,
  parameter logic [OPW-1:0]  OP_HALT = OPC_HALT,
  parameter logic [ALUW-1:0] ALU_ADD = ALUOP_ADD
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            con_ff,
  input  logic            stop,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Cout,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            PCin,
  output logic            Yin,
  output logic            Zin,
  output logic            IncPC,
  output logic            Read,
  output logic            GRA,
  output logic            GRB,
  output logic            GRC,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            CONin,
  output logic            LinkIn,
  output logic [ALUW-1:0] operation,
  output logic            run
);

  state_t       state_q, state_d, boundary_next;
  logic         stop_pend_q;
  ctrl_strobe_t strobes;

  // A stop seen mid-instruction is remembered until the next instruction boundary.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_RST;
      stop_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_HALT)
        stop_pend_q <= 1'b0;
      else if (stop)
        stop_pend_q <= 1'b1;
    end
  end

  always_comb begin
    boundary_next = (stop || stop_pend_q) ? ST_HALT : ST_T0;
    state_d       = state_q;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2:  state_d = ST_DEC;
      ST_DEC: begin
        case (opcode)
          OP_HALT: state_d = ST_HALT;
          OP_JR:   state_d = ST_JR3;
          OP_BR:   state_d = ST_BR3;
`ifdef CTRL_SEQ_JAL_EN
          OP_JAL:  state_d = ST_JAL3;
          OP_NOP:  state_d = boundary_next;
`else
          OP_JAL, OP_NOP: state_d = boundary_next;
`endif
          default: state_d = boundary_next;
        endcase
      end
      ST_JR3: state_d = boundary_next;
`ifdef CTRL_SEQ_JAL_EN
      ST_JAL3: state_d = ST_JAL4;
      ST_JAL4: state_d = boundary_next;
`endif
      ST_BR3:  state_d = ST_BR4;
      ST_BR4:  state_d = ST_BR5;
      ST_BR5:  state_d = ST_BR6;
      ST_BR6:  state_d = boundary_next;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  ctrl_decode #(
    .ALUW    (ALUW),
    .ALU_ADD (ALU_ADD)
  ) u_decode (
    .state     (state_q),
    .con_ff    (con_ff),
    .strobes   (strobes),
    .operation (operation)
  );

  assign PCout   = strobes.pc_out;
  assign Zlowout = strobes.zlow_out;
  assign MDRout  = strobes.mdr_out;
  assign Cout    = strobes.c_out;
  assign MARin   = strobes.mar_in;
  assign MDRin   = strobes.mdr_in;
  assign IRin    = strobes.ir_in;
  assign PCin    = strobes.pc_in;
  assign Yin     = strobes.y_in;
  assign Zin     = strobes.z_in;
  assign IncPC   = strobes.inc_pc;
  assign Read    = strobes.read;
  assign GRA     = strobes.gra;
  assign GRB     = strobes.grb;
  assign GRC     = strobes.grc;
  assign Rin     = strobes.r_in;
  assign Rout    = strobes.r_out;
  assign BAout   = strobes.ba_out;
  assign CONin   = strobes.con_in;
  assign LinkIn  = strobes.link_in;
  assign run     = strobes.run;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer.
// Expectations for OP_JAL follow CTRL_SEQ_JAL_EN.
module tb_control_sequencer;

  logic       Clock;
  logic       Reset;
  logic [4:0] opcode;
  logic       con_ff;
  logic       stop;
  logic PCout, Zlowout, MDRout, Cout, MARin, MDRin, IRin, PCin, Yin, Zin;
  logic IncPC, Read, GRA, GRB, GRC, Rin, Rout, BAout, CONin, LinkIn, run;
  logic [4:0] operation;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .PCin(PCin), .Yin(Yin), .Zin(Zin),
    .IncPC(IncPC), .Read(Read), .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .CONin(CONin), .LinkIn(LinkIn),
    .operation(operation), .run(run)
  );

  logic [20:0] sig;
  assign sig = {PCout, Zlowout, MDRout, Cout, MARin, MDRin, IRin, PCin, Yin, Zin,
                IncPC, Read, GRA, GRB, GRC, Rin, Rout, BAout, CONin, LinkIn, run};

  localparam logic [20:0] B_PCOUT = 21'd1 << 20;
  localparam logic [20:0] B_ZLOW  = 21'd1 << 19;
  localparam logic [20:0] B_MDROUT= 21'd1 << 18;
  localparam logic [20:0] B_COUT  = 21'd1 << 17;
  localparam logic [20:0] B_MARIN = 21'd1 << 16;
  localparam logic [20:0] B_MDRIN = 21'd1 << 15;
  localparam logic [20:0] B_IRIN  = 21'd1 << 14;
  localparam logic [20:0] B_PCIN  = 21'd1 << 13;
  localparam logic [20:0] B_YIN   = 21'd1 << 12;
  localparam logic [20:0] B_ZIN   = 21'd1 << 11;
  localparam logic [20:0] B_INCPC = 21'd1 << 10;
  localparam logic [20:0] B_READ  = 21'd1 << 9;
  localparam logic [20:0] B_GRA   = 21'd1 << 8;
  localparam logic [20:0] B_ROUT  = 21'd1 << 4;
  localparam logic [20:0] B_CONIN = 21'd1 << 2;
  localparam logic [20:0] B_LINK  = 21'd1 << 1;
  localparam logic [20:0] B_RUN   = 21'd1;

  localparam logic [20:0] E_OFF  = 21'd0;
  localparam logic [20:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [20:0] E_T1   = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [20:0] E_T2   = B_MDROUT | B_IRIN | B_RUN;
  localparam logic [20:0] E_DEC  = B_RUN;
  localparam logic [20:0] E_JR3  = B_GRA | B_ROUT | B_PCIN | B_RUN;
  localparam logic [20:0] E_JAL3 = B_PCOUT | B_LINK | B_RUN;
  localparam logic [20:0] E_JAL4 = B_GRA | B_ROUT | B_PCIN | B_RUN;
  localparam logic [20:0] E_BR3  = B_GRA | B_ROUT | B_CONIN | B_RUN;
  localparam logic [20:0] E_BR4  = B_PCOUT | B_YIN | B_RUN;
  localparam logic [20:0] E_BR5  = B_COUT | B_ZIN | B_RUN;
  localparam logic [20:0] E_BR6F = B_ZLOW | B_RUN;
  localparam logic [20:0] E_BR6T = B_ZLOW | B_PCIN | B_RUN;

  function automatic logic [4:0] exp_op(input logic [20:0] e);
    return (e == E_T0 || e == E_BR5) ? 5'h03 : 5'h00;
  endfunction

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // At most one bus driver per cycle, checked for the whole run.
  always @(negedge Clock) begin
    checks++;
    if ($countones({PCout, Zlowout, MDRout, Cout, Rout}) > 1) begin
      errors++;
      $display("FAIL bus_exclusive: drives=%b required at most one set",
               {PCout, Zlowout, MDRout, Cout, Rout});
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    stop  = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; opcode = 5'h1A; con_ff = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (sig !== E_OFF || operation !== 5'h00) begin
        errors++;
        $display("FAIL reset_hold %0d: sig=%h op=%h required sig=%h op=00", i, sig, operation, E_OFF);
      end
    end
    @(negedge Clock); Reset = 1'b0; #1;
    checks++;
    if (sig !== E_OFF) begin
      errors++;
      $display("FAIL reset_released_rst: sig=%h required %h", sig, E_OFF);
    end
    @(posedge Clock); #1;
    checks++;
    if (sig !== E_T0 || operation !== 5'h03) begin
      errors++;
      $display("FAIL reset_first_t0: sig=%h op=%h required sig=%h op=03", sig, operation, E_T0);
    end
  endtask

  task automatic test_jr();
    logic [20:0] es [5] = '{E_T1, E_T2, E_DEC, E_JR3, E_T0};
    opcode = 5'h13;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (sig !== es[i] || operation !== exp_op(es[i])) begin
        errors++;
        $display("FAIL jr step %0d: sig=%h op=%h required sig=%h op=%h", i, sig, operation, es[i], exp_op(es[i]));
      end
    end
  endtask

  task automatic test_nop();
    logic [4:0]  ops [2] = '{5'h1A, 5'h05};
    logic [20:0] es  [4] = '{E_T1, E_T2, E_DEC, E_T0};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 4; i++) begin
        @(posedge Clock); #1;
        checks++;
        if (sig !== es[i] || operation !== exp_op(es[i])) begin
          errors++;
          $display("FAIL nop op=%h step %0d: sig=%h op=%h required sig=%h", ops[k], i, sig, operation, es[i]);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [20:0] es [8];
    for (int k = 0; k < 2; k++) begin
      es = '{E_T1, E_T2, E_DEC, E_BR3, E_BR4, E_BR5, (k == 1) ? E_BR6T : E_BR6F, E_T0};
      opcode = 5'h12;
      con_ff = (k == 1);
      for (int i = 0; i < 8; i++) begin
        @(posedge Clock); #1;
        checks++;
        if (sig !== es[i] || operation !== exp_op(es[i])) begin
          errors++;
          $display("FAIL branch con=%0d step %0d: sig=%h op=%h required sig=%h op=%h",
                   k, i, sig, operation, es[i], exp_op(es[i]));
        end
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_jal();
`ifdef CTRL_SEQ_JAL_EN
    logic [20:0] es [6] = '{E_T1, E_T2, E_DEC, E_JAL3, E_JAL4, E_T0};
    int n = 6;
`else
    logic [20:0] es [6] = '{E_T1, E_T2, E_DEC, E_T0, E_T1, E_T2};
    int n = 4;
`endif
    opcode = 5'h14;
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (sig !== es[i] || operation !== exp_op(es[i])) begin
        errors++;
        $display("FAIL jal step %0d: sig=%h op=%h required sig=%h", i, sig, operation, es[i]);
      end
    end
  endtask

  task automatic test_stop_in_branch();
    logic [20:0] es [5] = '{E_T1, E_T2, E_DEC, E_BR3, E_BR4};
    logic [20:0] tail [5] = '{E_BR5, E_BR6T, E_OFF, E_OFF, E_OFF};
    opcode = 5'h12; con_ff = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (sig !== es[i]) begin
        errors++;
        $display("FAIL stop_br lead %0d: sig=%h required %h", i, sig, es[i]);
      end
    end
    stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      stop = 1'b0;
      checks++;
      if (sig !== tail[i] || operation !== exp_op(tail[i])) begin
        errors++;
        $display("FAIL stop_br tail %0d: sig=%h op=%h required sig=%h", i, sig, operation, tail[i]);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_halt_opcode();
    logic [20:0] es [4] = '{E_T1, E_T2, E_DEC, E_OFF};
    opcode = 5'h1B;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (sig !== es[i]) begin
        errors++;
        $display("FAIL halt_op step %0d: sig=%h required %h", i, sig, es[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      stop   = i[0];
      opcode = (i % 3 == 0) ? 5'h13 : 5'h12;
      @(posedge Clock); #1;
      checks++;
      if (sig !== E_OFF || operation !== 5'h00) begin
        errors++;
        $display("FAIL halt_hold %0d: sig=%h op=%h required sig=0 op=00", i, sig, operation);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_stop_boundary();
    logic [4:0] ops [2] = '{5'h1A, 5'h1B};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      repeat (3) @(posedge Clock);
      #1;
      checks++;
      if (sig !== E_DEC) begin
        errors++;
        $display("FAIL stop_dec op=%h: sig=%h required %h", ops[k], sig, E_DEC);
      end
      stop = 1'b1;
      @(posedge Clock); #1;
      stop = 1'b0;
      checks++;
      if (sig !== E_OFF || run !== 1'b0) begin
        errors++;
        $display("FAIL stop_halt op=%h: sig=%h run=%b required sig=0 run=0", ops[k], sig, run);
      end
      do_reset();
    end
  endtask

  task automatic test_reset_mid_br5();
    logic [20:0] es [6] = '{E_T1, E_T2, E_DEC, E_BR3, E_BR4, E_BR5};
    opcode = 5'h12;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (sig !== es[i] || operation !== exp_op(es[i])) begin
        errors++;
        $display("FAIL mid_reset lead %0d: sig=%h required %h", i, sig, es[i]);
      end
    end
    #3 Reset = 1'b1;
    #1;
    checks++;
    if (sig !== E_OFF || operation !== 5'h00) begin
      errors++;
      $display("FAIL mid_reset_async: sig=%h op=%h required sig=0 op=00", sig, operation);
    end
    @(posedge Clock); #1;
    checks++;
    if (sig !== E_OFF) begin
      errors++;
      $display("FAIL mid_reset_held: sig=%h required 0", sig);
    end
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
    checks++;
    if (sig !== E_T0 || operation !== 5'h03) begin
      errors++;
      $display("FAIL mid_reset_restart: sig=%h op=%h required sig=%h op=03", sig, operation, E_T0);
    end
  endtask

  initial begin
    test_reset();
    test_jr();
    test_nop();
    test_branch();
    test_jal();
    test_stop_in_branch();
    do_reset();
    test_halt_opcode();
    do_reset();
    test_stop_boundary();
    test_reset_mid_br5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
